secuenciador_suma_64: RTL and testbench

SECUENCIADOR_SUMA_64 -- requirements
Module: secuenciador_suma_64

---
 rtl/secuenciador_suma_64_if.sv | 29 ++
 rtl/secuenciador_suma_64.sv | 133 +++++++++++++
 tb/tb_secuenciador_suma_64.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/secuenciador_suma_64_if.sv
// Bus bundle for secuenciador_suma_64: input beats, external adder hookup and result handshake.
// slave is the sequencer's view; master is the surrounding environment's view.
interface secuenciador_suma_64_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_cin;
    logic [63:0] add_a;
    logic [63:0] add_b;
    logic        add_cin;
    logic [63:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        busy;

    modport slave (
        input  in_valid, in_data, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport master (
        output in_valid, in_data, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/secuenciador_suma_64.sv
// Collects two 64-bit operands as four 32-bit beats, drives an external combinational
// adder from the operand registers, and holds the registered result until it is taken.
module secuenciador_suma_64 (
    input logic                   clk,
    input logic                   rst_n,
    secuenciador_suma_64_if.slave bus
);

    typedef enum logic [2:0] {
        A_LO = 3'd0,
        A_HI = 3'd1,
        B_LO = 3'd2,
        B_HI = 3'd3,
        CALC = 3'd4,
        HOLD = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        in_ready_r;
    logic        in_ready_nx_s;
    logic        busy_r;
    logic        busy_nx_s;
    logic        out_valid_r;
    logic        out_valid_nx_s;
    logic        in_ready_s;
    logic        accept_s;
    logic [63:0] a_r;
    logic [63:0] b_r;
    logic        cin_r;
    logic [63:0] out_sum_r;
    logic        out_cout_r;
    logic        out_ovf_r;

    // Signed overflow: like-signed operands producing a result of the opposite sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

    assign in_ready_s = in_ready_r & rst_n;
    assign accept_s   = bus.in_valid & in_ready_s;

    // Next-state logic and next values of the registered status flags.
    always_comb begin
        state_s = state_r;
        case (state_r)
            A_LO: begin
                if (accept_s) state_s = A_HI;
                else          state_s = A_LO;
            end
            A_HI: begin
                if (accept_s) state_s = B_LO;
                else          state_s = A_HI;
            end
            B_LO: begin
                if (accept_s) state_s = B_HI;
                else          state_s = B_LO;
            end
            B_HI: begin
                if (accept_s) state_s = CALC;
                else          state_s = B_HI;
            end
            CALC: state_s = HOLD;
            HOLD: begin
                if (out_valid_r && bus.out_ready) state_s = A_LO;
                else                              state_s = HOLD;
            end
            default: state_s = A_LO;
        endcase
        in_ready_nx_s  = (state_s == A_LO) || (state_s == A_HI) ||
                         (state_s == B_LO) || (state_s == B_HI);
        busy_nx_s      = (state_s != A_LO);
        out_valid_nx_s = (state_s == HOLD);
    end

    // State register plus flags registered from the next state, so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= A_LO;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_nx_s;
            busy_r      <= busy_nx_s;
            out_valid_r <= out_valid_nx_s;
        end
    end

    // Operand slice loading on accepted beats and result capture in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= 64'd0;
            b_r        <= 64'd0;
            cin_r      <= 1'b0;
            out_sum_r  <= 64'd0;
            out_cout_r <= 1'b0;
            out_ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                A_LO: if (accept_s) a_r[31:0]  <= bus.in_data;
                A_HI: if (accept_s) a_r[63:32] <= bus.in_data;
                B_LO: if (accept_s) b_r[31:0]  <= bus.in_data;
                B_HI: begin
                    if (accept_s) begin
                        b_r[63:32] <= bus.in_data;
                        cin_r      <= bus.in_cin;
                    end
                end
                CALC: begin
                    out_sum_r  <= bus.add_sum;
                    out_cout_r <= bus.add_cout;
                    out_ovf_r  <= signed_ovf(a_r[63], b_r[63], bus.add_sum[63]);
                end
                default: begin
                    out_sum_r <= out_sum_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.add_a     = a_r;
    assign bus.add_b     = b_r;
    assign bus.add_cin   = cin_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_cout  = out_cout_r;
    assign bus.out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_secuenciador_suma_64.sv
// Self-checking bench for secuenciador_suma_64: directed corner cases plus randomized
// transactions with random gaps and hold times, checked against an arithmetic model.
module tb_secuenciador_suma_64;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [63:0] last_sum;

    secuenciador_suma_64_if bus ();

    secuenciador_suma_64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External combinational 64-bit adder
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {64'd0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: 65-bit unsigned sum for sum/carry, 66-bit signed sum for overflow.
    function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [64:0]        u;
        logic signed [65:0] s;
        logic               ovf;
        u   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        s   = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, cin});
        ovf = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
        return {ovf, u[64], u[63:0]};
    endfunction

    // One beat, preceded by `gap` idle cycles of junk data; returns #1 after the accepting edge.
    task automatic beat(input logic [31:0] d, input logic c, input int gap);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
            bus.in_cin   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_cin   = c;
        @(negedge clk);
        check_val("in_ready_load", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_cin   = 1'($urandom);
    endtask

    task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic cin,
                           input logic cin_other, input int gap, input int hold);
        logic [65:0] r;
        r = ref_add(a, b, cin);
        beat(a[31:0],  cin_other, gap);
        beat(a[63:32], cin_other, gap);
        beat(b[31:0],  cin_other, gap);
        beat(b[63:32], cin,       gap);
        @(negedge clk);
        check_val("calc_valid", {63'd0, bus.out_valid}, 64'd0);
        check_val("calc_ready", {63'd0, bus.in_ready},  64'd0);
        check_val("calc_busy",  {63'd0, bus.busy},      64'd1);
        @(posedge clk);
        @(negedge clk);
        check_val("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        check_val("sum",        bus.out_sum,            r[63:0]);
        check_val("cout",       {63'd0, bus.out_cout},  {63'd0, r[64]});
        check_val("ovf",        {63'd0, bus.out_ovf},   {63'd0, r[65]});
        // Offer a new beat throughout HOLD; it must never be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check_val("stall_valid", {63'd0, bus.out_valid}, 64'd1);
            check_val("stall_sum",   bus.out_sum,            r[63:0]);
            check_val("stall_flags", {62'd0, bus.out_cout, bus.out_ovf}, {62'd0, r[64], r[65]});
            check_val("stall_ready", {63'd0, bus.in_ready},  64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check_val("post_valid", {63'd0, bus.out_valid}, 64'd0);
        check_val("post_busy",  {63'd0, bus.busy},      64'd0);
        check_val("post_ready", {63'd0, bus.in_ready},  64'd1);
        check_val("post_stale", bus.out_sum,            r[63:0]);
        last_sum = r[63:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        last_sum      = 64'd0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {63'd0, bus.in_ready},  64'd0);
        check_val("rst_busy",  {63'd0, bus.busy},      64'd0);
        check_val("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check_val("rst_sum",   bus.out_sum,            64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("first_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        run_txn(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0, 0);
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 1);
        run_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0, 0);
        run_txn(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, 1, 0);
        run_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 2, 5);

        // Abort after three beats: everything clears at once, then a fresh transaction.
        beat(32'hDEAD_BEEF, 1'b1, 0);
        beat(32'h0BAD_F00D, 1'b1, 1);
        beat(32'h1357_9BDF, 1'b1, 0);
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        #1;
        check_val("abort_ready", {63'd0, bus.in_ready},  64'd0);
        check_val("abort_busy",  {63'd0, bus.busy},      64'd0);
        check_val("abort_valid", {63'd0, bus.out_valid}, 64'd0);
        check_val("abort_sum",   bus.out_sum,            64'd0);
        check_val("abort_flags", {62'd0, bus.out_cout, bus.out_ovf}, 64'd0);
        check_val("abort_a",     bus.add_a,              64'd0);
        check_val("abort_b",     bus.add_b,              64'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(64'd5, 64'd3, 1'b0, 1'b0, 0, 0);
        check_val("abort_fresh", last_sum, 64'd8);

        for (int i = 0; i < 24; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 1) rb = ~ra;
            if (i % 4 == 2) ra[63] = rb[63];
            run_txn(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
